// File: rtl/mode_fsm_gen_if.sv
// Handshake bundle for mode_fsm_gen: step/dir/load requests from the harness,
// registered state and status flags back from the FSM.
interface mode_fsm_gen_if #(
  parameter int NUM_STATES = 4
);
  localparam int STATE_W = $clog2(NUM_STATES);

  logic                  step;
  logic                  dir;
  logic                  load;
  logic [STATE_W-1:0]    load_state;
  logic [STATE_W-1:0]    state;
  logic                  out;
  logic                  busy;
  logic                  stall;
  logic                  wrap;
  logic                  load_err;
  logic [NUM_STATES-1:0] visited;
  logic                  all_visited;

  modport master (
    output step, dir, load, load_state,
    input  state, out, busy, stall, wrap, load_err, visited, all_visited
  );

  modport slave (
    input  step, dir, load, load_state,
    output state, out, busy, stall, wrap, load_err, visited, all_visited
  );
endinterface

// File: rtl/mode_fsm_gen.sv
// Parametrised cyclic mode FSM with dwell time, range-checked load and wrap flag.
// Optional per-state visit map enabled by defining MODE_FSM_GEN_VISIT_MAP_EN.
module mode_fsm_gen #(
  parameter int NUM_STATES = 4,
  parameter int OUT_STATE  = 2,
  parameter int DWELL      = 2
) (
  input logic           clk,
  input logic           rst,
  mode_fsm_gen_if.slave bus
);
  localparam int STATE_W = $clog2(NUM_STATES);

  localparam logic [STATE_W-1:0] MAX_S   = STATE_W'(NUM_STATES - 1);
  localparam logic [STATE_W-1:0] OUT_S   = STATE_W'(OUT_STATE);
  localparam logic [STATE_W:0]   NS_EXT  = (STATE_W + 1)'(NUM_STATES);
  localparam logic [3:0]         DWELL_C = 4'(DWELL);

  logic [STATE_W-1:0] state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               out_q, out_d;
  logic               wrap_q, wrap_d;
  logic               load_err_q, load_err_d;
  logic               busy;
  logic               load_ok;

  // Wrap is explicit so non-power-of-two state counts never alias.
  function automatic logic [STATE_W-1:0] next_up(input logic [STATE_W-1:0] s);
    return (s == MAX_S) ? '0 : s + 1'b1;
  endfunction

  function automatic logic [STATE_W-1:0] next_dn(input logic [STATE_W-1:0] s);
    return (s == '0) ? MAX_S : s - 1'b1;
  endfunction

  assign busy    = (cnt_q != 4'd0);
  assign load_ok = ({1'b0, bus.load_state} < NS_EXT);

  always_comb begin
    state_d    = state_q;
    cnt_d      = busy ? cnt_q - 4'd1 : cnt_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (bus.load) begin
      if (load_ok) begin
        state_d = bus.load_state;
        cnt_d   = DWELL_C;
      end else begin
        // Rejected load freezes state and dwell; any coincident step is dropped.
        load_err_d = 1'b1;
        cnt_d      = cnt_q;
      end
    end else if (bus.step && !busy) begin
      if (!bus.dir) begin
        state_d = next_up(state_q);
        wrap_d  = (state_q == MAX_S);
      end else begin
        state_d = next_dn(state_q);
        wrap_d  = (state_q == '0);
      end
      cnt_d = DWELL_C;
    end
    out_d = (state_d == OUT_S);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= '0;
      cnt_q      <= 4'd0;
      out_q      <= 1'b0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      out_q      <= out_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.state    = state_q;
  assign bus.out      = out_q;
  assign bus.busy     = busy;
  assign bus.stall    = bus.step && busy && !bus.load;
  assign bus.wrap     = wrap_q;
  assign bus.load_err = load_err_q;

`ifdef MODE_FSM_GEN_VISIT_MAP_EN
  logic [NUM_STATES-1:0] visited_q, visited_d;

  assign visited_d = visited_q | (NUM_STATES'(1) << state_d);

  always_ff @(posedge clk) begin
    if (rst) visited_q <= NUM_STATES'(1);
    else     visited_q <= visited_d;
  end

  assign bus.visited     = visited_q;
  assign bus.all_visited = &visited_q;
`else
  assign bus.visited     = '0;
  assign bus.all_visited = 1'b0;
`endif
endmodule

// File: tb/tb_mode_fsm_gen.sv
// Directed bench for mode_fsm_gen: a 4-state and a 5-state instance share clock and reset.
module tb_mode_fsm_gen;
`ifdef MODE_FSM_GEN_VISIT_MAP_EN
  localparam bit VM = 1'b1;
`else
  localparam bit VM = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mode_fsm_gen_if #(.NUM_STATES(4)) b4 ();
  mode_fsm_gen_if #(.NUM_STATES(5)) b5 ();

  mode_fsm_gen #(.NUM_STATES(4), .OUT_STATE(2), .DWELL(2)) u4 (
    .clk(clk), .rst(rst), .bus(b4.slave)
  );
  mode_fsm_gen #(.NUM_STATES(5), .OUT_STATE(2), .DWELL(2)) u5 (
    .clk(clk), .rst(rst), .bus(b5.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int exp_s  [12] = '{0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0, 0};
  int exp_st [12] = '{0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    b4.step = 0; b4.dir = 0; b4.load = 0; b4.load_state = '0;
    b5.step = 0; b5.dir = 0; b5.load = 0; b5.load_state = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] ev;
    ev = VM ? 4'b0001 : 4'b0000;
    idle_inputs();
    b4.step = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (b4.state !== 2'd0) begin errors++; $display("FAIL reset_state cyc%0d: got %0d expected 0", i, b4.state); end
      checks++; if (b4.out !== 1'b0) begin errors++; $display("FAIL reset_out cyc%0d: got %b expected 0", i, b4.out); end
      checks++; if (b4.busy !== 1'b0) begin errors++; $display("FAIL reset_busy cyc%0d: got %b expected 0", i, b4.busy); end
      checks++; if (b4.visited !== ev) begin errors++; $display("FAIL reset_visited cyc%0d: got %b expected %b", i, b4.visited, ev); end
    end
    rst = 1'b0;
    b4.dir = 1'b0;
    tick();
    b4.step = 1'b0;
    checks++; if (b4.state !== 2'd1) begin errors++; $display("FAIL first_step: got %0d expected 1", b4.state); end
    checks++; if (b4.all_visited !== 1'b0) begin errors++; $display("FAIL reset_all_visited: got %b expected 0", b4.all_visited); end
  endtask

  task automatic test_step_up();
    do_reset();
    b4.step = 1'b1;
    b4.dir  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #1;
      checks++; if (b4.state !== 2'(exp_s[i])) begin errors++; $display("FAIL up_state cyc%0d: got %0d expected %0d", i, b4.state, exp_s[i]); end
      checks++; if (b4.stall !== 1'(exp_st[i])) begin errors++; $display("FAIL up_stall cyc%0d: got %b expected %0d", i, b4.stall, exp_st[i]); end
      checks++; if (b4.wrap !== (i == 10)) begin errors++; $display("FAIL up_wrap cyc%0d: got %b expected %b", i, b4.wrap, (i == 10)); end
      checks++; if (b4.out !== (exp_s[i] == 2)) begin errors++; $display("FAIL up_out cyc%0d: got %b expected %b", i, b4.out, (exp_s[i] == 2)); end
      tick();
    end
    b4.step = 1'b0;
  endtask

  task automatic test_step_down();
    do_reset();
    b4.step = 1'b1;
    b4.dir  = 1'b1;
    tick();
    b4.step = 1'b0;
    b4.dir  = 1'b0;
    checks++; if (b4.state !== 2'd3) begin errors++; $display("FAIL down_state: got %0d expected 3", b4.state); end
    checks++; if (b4.wrap !== 1'b1) begin errors++; $display("FAIL down_wrap: got %b expected 1", b4.wrap); end
    tick();
    checks++; if (b4.wrap !== 1'b0) begin errors++; $display("FAIL down_wrap_clear: got %b expected 0", b4.wrap); end
    checks++; if (b4.busy !== 1'b1) begin errors++; $display("FAIL down_busy: got %b expected 1", b4.busy); end
  endtask

  task automatic test_load_busy();
    do_reset();
    b4.step = 1'b1;
    tick();
    b4.load = 1'b1;
    b4.load_state = 2'd3;
    #1;
    checks++; if (b4.busy !== 1'b1) begin errors++; $display("FAIL lb_pre_busy: got %b expected 1", b4.busy); end
    checks++; if (b4.stall !== 1'b0) begin errors++; $display("FAIL lb_stall: got %b expected 0", b4.stall); end
    tick();
    b4.load = 1'b0;
    b4.step = 1'b0;
    checks++; if (b4.state !== 2'd3) begin errors++; $display("FAIL lb_state: got %0d expected 3", b4.state); end
    checks++; if (b4.wrap !== 1'b0) begin errors++; $display("FAIL lb_wrap: got %b expected 0", b4.wrap); end
    checks++; if (b4.busy !== 1'b1) begin errors++; $display("FAIL lb_busy1: got %b expected 1", b4.busy); end
    tick();
    checks++; if (b4.busy !== 1'b1) begin errors++; $display("FAIL lb_busy2: got %b expected 1", b4.busy); end
    tick();
    checks++; if (b4.busy !== 1'b0) begin errors++; $display("FAIL lb_busy3: got %b expected 0", b4.busy); end
    b4.load = 1'b1;
    tick();
    b4.load = 1'b0;
    checks++; if (b4.busy !== 1'b1) begin errors++; $display("FAIL lb_self_busy: got %b expected 1", b4.busy); end
    checks++; if (b4.state !== 2'd3) begin errors++; $display("FAIL lb_self_state: got %0d expected 3", b4.state); end
  endtask

  task automatic test_n5();
    do_reset();
    b5.load = 1'b1;
    b5.load_state = 3'd6;
    tick();
    b5.load = 1'b0;
    checks++; if (b5.state !== 3'd0) begin errors++; $display("FAIL n5_err_state: got %0d expected 0", b5.state); end
    checks++; if (b5.load_err !== 1'b1) begin errors++; $display("FAIL n5_load_err: got %b expected 1", b5.load_err); end
    checks++; if (b5.busy !== 1'b0) begin errors++; $display("FAIL n5_err_busy: got %b expected 0", b5.busy); end
    tick();
    checks++; if (b5.load_err !== 1'b0) begin errors++; $display("FAIL n5_load_err_clear: got %b expected 0", b5.load_err); end
    b5.load = 1'b1;
    b5.load_state = 3'd7;
    b5.step = 1'b1;
    tick();
    b5.load = 1'b0;
    b5.step = 1'b0;
    checks++; if (b5.state !== 3'd0) begin errors++; $display("FAIL n5_drop_step: got %0d expected 0", b5.state); end
    b5.load = 1'b1;
    b5.load_state = 3'd4;
    tick();
    b5.load = 1'b0;
    checks++; if (b5.state !== 3'd4) begin errors++; $display("FAIL n5_load4: got %0d expected 4", b5.state); end
    tick();
    tick();
    b5.step = 1'b1;
    tick();
    b5.step = 1'b0;
    checks++; if (b5.state !== 3'd0) begin errors++; $display("FAIL n5_wrap_state: got %0d expected 0", b5.state); end
    checks++; if (b5.wrap !== 1'b1) begin errors++; $display("FAIL n5_wrap: got %b expected 1", b5.wrap); end
  endtask

  task automatic test_visit_and_rst();
    logic [3:0] ev;
    do_reset();
    for (int s = 1; s < 4; s++) begin
      b4.load = 1'b1;
      b4.load_state = 2'(s);
      tick();
    end
    b4.load = 1'b0;
    ev = VM ? 4'b1111 : 4'b0000;
    checks++; if (b4.visited !== ev) begin errors++; $display("FAIL vis_map: got %b expected %b", b4.visited, ev); end
    checks++; if (b4.all_visited !== VM) begin errors++; $display("FAIL vis_all: got %b expected %b", b4.all_visited, VM); end
    b4.load = 1'b1;
    b4.load_state = 2'd2;
    tick();
    b4.load = 1'b0;
    checks++; if (b4.out !== 1'b1) begin errors++; $display("FAIL vis_out2: got %b expected 1", b4.out); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ev = VM ? 4'b0001 : 4'b0000;
    checks++; if (b4.state !== 2'd0) begin errors++; $display("FAIL rst_mid_state: got %0d expected 0", b4.state); end
    checks++; if (b4.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", b4.busy); end
    checks++; if (b4.visited !== ev) begin errors++; $display("FAIL rst_mid_visited: got %b expected %b", b4.visited, ev); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_step_up();
    test_step_down();
    test_load_busy();
    test_n5();
    test_visit_and_rst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mode_fsm_gen.md
# mode_fsm_gen

Parametrised cyclic mode state machine, successor to the team's fixed 2-bit demo FSM. Holds one of NUM_STATES states, advances up or down on a step request, enforces a minimum dwell time per state, supports direct state load with range checking, and flags wrap-around. It is a formal/coverage target in the verification platform: a harness drives step/dir/load and checks the outputs. An optional per-state visit map reports state coverage.

## Interface
- NUM_STATES, 4: number of legal states, 2..16; states encoded 0..NUM_STATES-1.
- STATE_W, $clog2(NUM_STATES): state field width (derived, not overridden).
- OUT_STATE, 2: state in which `out` is high; legal range 1..NUM_STATES-1.
- DWELL, 2: minimum cycles spent in a state before a step is accepted; 0..15.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- step  in  1  request to advance one state.
- dir  in  1  step direction: 0 = up (+1), 1 = down (-1).
- load  in  1  load `load_state` into the state register.
- load_state  in  STATE_W  target state for load.
- state  out  STATE_W  current state (registered).
- out  out  1  high when state == OUT_STATE (registered).
- busy  out  1  dwell counter nonzero; steps are refused.
- stall  out  1  combinational: step && busy && !load.
- wrap  out  1  one-cycle pulse after an up step N-1->0 or down step 0->N-1.
- load_err  out  1  one-cycle pulse after a load with load_state >= NUM_STATES.
- visited  out  NUM_STATES  sticky bit per state entered since reset.
- all_visited  out  1  &visited.

## Operation
- Reset values: state=0, out=0, dwell counter=0 (busy=0), wrap=0, load_err=0, visited=1 (bit 0 only), all_visited=0. rst has priority over every input, including mid-dwell.
- Priority per cycle: rst > load > step.
- Load, in range: state <= load_state regardless of busy; dwell counter <= DWELL, including a load to the current state; wrap=0.
- Load, out of range: state and dwell counter unchanged; load_err pulses; a coincident step is also dropped.
- Step accepted when !busy && !load: state <= state±1 modulo NUM_STATES (non-power-of-two wrap done explicitly, never by truncation); dwell counter <= DWELL; wrap pulses on the wrap transitions only.
- Step with busy: ignored, stall high that cycle. Requests are not queued.
- Dwell counter decrements by 1 each cycle while nonzero and no new load/step occurs.
- visited[s] set on the cycle state becomes s; cleared only by rst.
- The state register never holds a value >= NUM_STATES.

## Timing
- Accepted step/load at edge t: new state, out, wrap, load_err visible after edge t (1-cycle latency).
- busy high for exactly DWELL cycles after each state change; next step accepted at cycle t+DWELL+1 at the earliest. DWELL=0: a step is accepted every cycle.
- stall is combinational from the current inputs and busy. All other outputs are registered.
- wrap and load_err are single-cycle pulses that do not repeat unless the event repeats.

## Configuration
- MODE_FSM_GEN_VISIT_MAP_EN defined: visited and all_visited are implemented as described.
- Undefined: visited is tied to 0 and all_visited to 0. No visit registers are synthesised. All other behaviour is identical.

## Test plan
- rst held 3 cycles, then released: state=0, out=0, busy=0 and visited=4'b0001 every cycle of reset. The first post-reset step (dir=0) gives state=1 on the next cycle.
- Defaults, step held high with dir=0 for 12 cycles after reset: state goes 0,1,1,1,2,2,2,3,3,3,0,... (advances every 3 cycles). stall is high on the 2 busy cycles of each state. wrap pulses once on 3->0. out is high only while state=2.
- At state=0, one accepted step with dir=1: state=3 and wrap pulses 1 cycle.
- At state=1 with busy=1: load=1, load_state=3 together with step=1 -> state=3, busy for 2 cycles, wrap=0, stall=0.
- NUM_STATES=5: load_state=6 -> state unchanged, load_err pulses 1 cycle. Up steps from 4 -> state=0 and wrap pulses.
- Macro defined: visit states 0..3 -> all_visited=1. rst mid-dwell at state=2 -> next cycle state=0, busy=0, visited=4'b0001.
